// File: rtl/stage_pkg.sv
// Shared definitions for the stage sequencer: FSM encoding, enable-bundle
// bit positions and the configuration legality check.
package stage_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle    = 2'd0;
    localparam state_t StRun     = 2'd1;
    localparam state_t StWaitMem = 2'd2;
    localparam state_t StHalted  = 2'd3;

    // Bit positions inside the datapath enable bundle.
    localparam int unsigned NumEn = 9;
    localparam int unsigned EnIr  = 0;
    localparam int unsigned EnPc  = 1;
    localparam int unsigned EnRa  = 2;
    localparam int unsigned EnRb  = 3;
    localparam int unsigned EnRz  = 4;
    localparam int unsigned EnRm  = 5;
    localparam int unsigned EnRy  = 6;
    localparam int unsigned EnRom = 7;
    localparam int unsigned EnRf  = 8;

    localparam int unsigned MinStages = 5;
    localparam int unsigned MaxStages = 7;

    // Stage count must be in range and representable on the Stage port.
    function automatic bit num_stages_legal(int unsigned n, int unsigned stage_w);
        return (n >= MinStages) && (n <= MaxStages) && (n < (32'd1 << stage_w));
    endfunction

endpackage

// File: rtl/stage_decode.sv
// Combinational decode of FSM state and current stage into the nine
// datapath enables.
module stage_decode
    import stage_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned STAGE_W    = 3
) (
    input  state_t             state_i,
    input  logic [STAGE_W-1:0] stage_i,
    input  logic               nop_i,
    input  logic               run_i,
    input  logic               stall_i,
    input  logic               halt_i,
    output logic [NumEn-1:0]   en_o
);

    localparam logic [STAGE_W-1:0] FirstStage = STAGE_W'(1);
    localparam logic [STAGE_W-1:0] LastStage  = STAGE_W'(NUM_STAGES);

    // Per-stage enable map; nop only suppresses the data-carrying enables.
    always_comb begin
        en_o = '0;
        case (state_i)
            StIdle: begin
                // Priming fetch for the first instruction.
                en_o[EnIr]  = run_i;
                en_o[EnRom] = run_i;
            end
            StRun, StWaitMem: begin
                if (!stall_i) begin
                    if (stage_i == FirstStage) begin
                        if (!halt_i) begin
                            en_o[EnPc] = 1'b1;
                            en_o[EnRa] = !nop_i;
                            en_o[EnRb] = !nop_i;
                        end
                    end else if (stage_i == STAGE_W'(2)) begin
                        en_o[EnRz] = !nop_i;
                        en_o[EnRm] = !nop_i;
                    end else if (stage_i == STAGE_W'(3)) begin
                        en_o[EnRy] = !nop_i;
                    end else if (stage_i == LastStage) begin
                        en_o[EnIr]  = 1'b1;
                        en_o[EnRom] = 1'b1;
                        en_o[EnRf]  = !nop_i;
                    end
                end
            end
            default: en_o = '0;
        endcase
    end

endmodule

// File: rtl/stage_sequencer.sv
// Pipeline stage sequencer: owns the stage counter, waits on memory with a
// watchdog, handles stall/NOP/halt and counts retired instructions.
module stage_sequencer
    import stage_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned STAGE_W    = 3,
    parameter int unsigned WAIT_MAX   = 15,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Run,
    input  logic               Stall,
    input  logic               NOP_FLAG,
    input  logic               HALT_FLAG,
    input  logic               Mem_Ready,
    output logic [STAGE_W-1:0] Stage,
    output logic               IR_Enable,
    output logic               PC_Enable,
    output logic               RA_Enable,
    output logic               RB_Enable,
    output logic               RZ_Enable,
    output logic               RM_Enable,
    output logic               RY_Enable,
    output logic               ROM1_Read,
    output logic               RF_WRITE,
    output logic               Halted,
    output logic               Mem_Timeout,
    output logic [CNT_W-1:0]   Instr_Count
);

    if (!num_stages_legal(NUM_STAGES, STAGE_W)) begin : g_bad_cfg
        $error("stage_sequencer: NUM_STAGES must be 5..7 and fit in STAGE_W");
    end

    localparam int unsigned WaitW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [STAGE_W-1:0] FirstStage   = STAGE_W'(1);
    localparam logic [STAGE_W-1:0] LastMemStage = STAGE_W'(NUM_STAGES - 1);
    localparam logic [STAGE_W-1:0] LastStage    = STAGE_W'(NUM_STAGES);
    localparam logic [WaitW-1:0]   WaitLimit    = WaitW'(WAIT_MAX);

    state_t             state_q, state_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic               nop_q, nop_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               mem_gate;
    logic               nop_eff;
    logic [NumEn-1:0]   en_raw;
    logic [NumEn-1:0]   en;

    // State and counter registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= StIdle;
            stage_q   <= '0;
            nop_q     <= 1'b0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            nop_q     <= nop_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
        end
    end

    // Only the last memory stage of a real instruction waits on memory.
    assign mem_gate = (stage_q == LastMemStage) && !nop_q;

    // Next-state: stall > halt > memory wait > advance.
    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        nop_d     = nop_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        count_d   = count_q;
        case (state_q)
            StIdle: begin
                if (Run) begin
                    state_d = StRun;
                    stage_d = FirstStage;
                end
            end
            StRun, StWaitMem: begin
                if (Stall) begin
                    state_d = state_q;
                end else if ((stage_q == FirstStage) && HALT_FLAG) begin
                    state_d = StHalted;
                end else if (mem_gate && (wait_q != WaitLimit) && !Mem_Ready) begin
                    state_d = StWaitMem;
                    wait_d  = wait_q + WaitW'(1);
                end else begin
                    state_d = StRun;
                    wait_d  = '0;
                    // Watchdog expiry advances as if ready, even if ready rose now.
                    if (mem_gate && (wait_q == WaitLimit)) begin
                        timeout_d = 1'b1;
                    end
                    if (stage_q == FirstStage) begin
                        nop_d = NOP_FLAG;
                    end
                    if (stage_q == LastStage) begin
                        stage_d = FirstStage;
                        if (!nop_q) begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end else begin
                        stage_d = stage_q + STAGE_W'(1);
                    end
                end
            end
            default: state_d = state_q;
        endcase
    end

    // Stage 1 has not yet latched the NOP flag, so it decodes the live one.
    assign nop_eff = (stage_q == FirstStage) ? NOP_FLAG : nop_q;

    stage_decode #(
        .NUM_STAGES (NUM_STAGES),
        .STAGE_W    (STAGE_W)
    ) u_decode (
        .state_i (state_q),
        .stage_i (stage_q),
        .nop_i   (nop_eff),
        .run_i   (Run),
        .stall_i (Stall),
        .halt_i  (HALT_FLAG),
        .en_o    (en_raw)
    );

    // Outputs; a reset cycle drives no enables so a mid-instruction reset writes nothing.
    always_comb begin
        en          = Reset ? '0 : en_raw;
        Stage       = stage_q;
        Halted      = (state_q == StHalted);
        Mem_Timeout = timeout_q;
        Instr_Count = count_q;
        IR_Enable   = en[EnIr];
        PC_Enable   = en[EnPc];
        RA_Enable   = en[EnRa];
        RB_Enable   = en[EnRb];
        RZ_Enable   = en[EnRz];
        RM_Enable   = en[EnRm];
        RY_Enable   = en[EnRy];
        ROM1_Read   = en[EnRom];
        RF_WRITE    = en[EnRf];
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer with a behavioural reference model.
module tb_stage_sequencer;

    localparam int NS = 5;
    localparam int SW = 3;
    localparam int WM = 15;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, run = 1'b0, stall = 1'b0, nop = 1'b0, halt = 1'b0, mrdy = 1'b1;
    logic [SW-1:0] stage;
    logic ir, pc, ra, rb, rz, rm, ry, rom, rf, halted, mto;
    logic [CW-1:0] icnt;

    stage_sequencer #(
        .NUM_STAGES (NS),
        .STAGE_W    (SW),
        .WAIT_MAX   (WM),
        .CNT_W      (CW)
    ) dut (
        .Clock       (clk),
        .Reset       (rst),
        .Run         (run),
        .Stall       (stall),
        .NOP_FLAG    (nop),
        .HALT_FLAG   (halt),
        .Mem_Ready   (mrdy),
        .Stage       (stage),
        .IR_Enable   (ir),
        .PC_Enable   (pc),
        .RA_Enable   (ra),
        .RB_Enable   (rb),
        .RZ_Enable   (rz),
        .RM_Enable   (rm),
        .RY_Enable   (ry),
        .ROM1_Read   (rom),
        .RF_WRITE    (rf),
        .Halted      (halted),
        .Mem_Timeout (mto),
        .Instr_Count (icnt)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: mode 0 idle, 1 executing, 2 halted.
    int m_mode = 0, m_stage = 0, m_wait = 0, m_cnt = 0;
    bit m_nop = 1'b0, m_to = 1'b0;

    wire [8:0]  en_dut = {rf, rom, ry, rm, rz, rb, ra, pc, ir};
    wire [29:0] obs    = {stage, halted, mto, icnt, en_dut};

    function automatic logic [8:0] exp_en();
        logic [8:0] e;
        bit n;
        e = '0;
        if (rst) return e;
        if (m_mode == 0) begin
            e[0] = run;
            e[7] = run;
        end else if (m_mode == 1 && !stall) begin
            n = (m_stage == 1) ? nop : m_nop;
            case (m_stage)
                1: if (!halt) begin e[1] = 1'b1; e[2] = !n; e[3] = !n; end
                2: begin e[4] = !n; e[5] = !n; end
                3: e[6] = !n;
                NS: begin e[0] = 1'b1; e[7] = 1'b1; e[8] = !n; end
                default: e = '0;
            endcase
        end
        return e;
    endfunction

    function automatic logic [29:0] expv();
        return {SW'(m_stage), (m_mode == 2), m_to, CW'(m_cnt), exp_en()};
    endfunction

    task automatic model_step();
        if (rst) begin
            m_mode = 0; m_stage = 0; m_nop = 0; m_wait = 0; m_to = 0; m_cnt = 0;
        end else if (m_mode == 0) begin
            if (run) begin m_mode = 1; m_stage = 1; end
        end else if (m_mode == 1 && !stall) begin
            if (m_stage == 1 && halt) begin
                m_mode = 2;
            end else if (m_stage == NS - 1 && !m_nop && m_wait < WM && !mrdy) begin
                m_wait++;
            end else begin
                if (m_stage == NS - 1 && !m_nop && m_wait == WM) m_to = 1'b1;
                if (m_stage == NS && !m_nop) m_cnt = (m_cnt + 1) % (1 << CW);
                if (m_stage == 1) m_nop = nop;
                m_wait  = 0;
                m_stage = m_stage % NS + 1;
            end
        end
    endtask

    // One clock: update the model on the edge, return just after the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; stall = 1'b0; nop = 1'b0; halt = 1'b0; mrdy = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Runs one instruction from stage 1, holding Mem_Ready low for `lows` stage-4 cycles.
    task automatic mem_instr(input int lows, output int s4, output int cyc);
        int low_seen;
        bit left;
        low_seen = 0; left = 1'b0; s4 = 0; cyc = 0;
        while (!left && cyc < 60) begin
            if (stage == SW'(NS - 1) && low_seen < lows) begin
                mrdy = 1'b0;
                low_seen++;
            end else begin
                mrdy = 1'b1;
            end
            #1;
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL mem_model cyc=%0d got=%h exp=%h", cyc, obs, expv());
            end
            if (stage == SW'(NS - 1)) s4++;
            tick();
            cyc++;
            if (stage == SW'(1)) left = 1'b1;
        end
        mrdy = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b1;
        tick();
        tick();
        #1;
        vectors++;
        if ({stage, halted, mto, icnt, en_dut} !== '0) begin
            miscompares++;
            $display("FAIL reset_values got=%h exp=0", {stage, halted, mto, icnt, en_dut});
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (en_dut !== 9'h081) begin
            miscompares++;
            $display("FAIL idle_run_fetch got=%h exp=081", en_dut);
        end
        run = 1'b0;
        #1;
        vectors++;
        if (obs !== expv()) begin
            miscompares++;
            $display("FAIL idle_model got=%h exp=%h", obs, expv());
        end
    endtask

    task automatic test_normal();
        int es;
        do_reset();
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 2 * NS; i++) begin
            #1;
            es = i % NS + 1;
            vectors++;
            if (stage !== SW'(es)) begin
                miscompares++;
                $display("FAIL normal_stage i=%0d got=%0d exp=%0d", i, stage, es);
            end
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL normal_model i=%0d got=%h exp=%h", i, obs, expv());
            end
            if (es == 1 && {pc, ra, rb} !== 3'b111) begin
                miscompares++;
                $display("FAIL normal_stage1_en got=%b exp=111", {pc, ra, rb});
            end
            if (es == NS && {ir, rom, rf} !== 3'b111) begin
                miscompares++;
                $display("FAIL normal_wb_en got=%b exp=111", {ir, rom, rf});
            end
            tick();
        end
        vectors++;
        if (icnt !== CW'(2)) begin
            miscompares++;
            $display("FAIL normal_count got=%0d exp=2", icnt);
        end
    endtask

    task automatic test_nop();
        int pcs, irs;
        logic bad;
        pcs = 0; irs = 0; bad = 1'b0;
        nop = 1'b1;
        for (int i = 0; i < NS; i++) begin
            #1;
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL nop_model i=%0d got=%h exp=%h", i, obs, expv());
            end
            pcs += int'(pc);
            irs += int'(ir);
            bad |= ra | rb | rz | rm | ry | rf;
            tick();
            nop = 1'($urandom % 2);
        end
        nop = 1'b0;
        vectors++;
        if (bad !== 1'b0 || pcs != 1 || irs != 1) begin
            miscompares++;
            $display("FAIL nop_enables got=bad%b pc%0d ir%0d exp=bad0 pc1 ir1", bad, pcs, irs);
        end
        vectors++;
        if (icnt !== CW'(2)) begin
            miscompares++;
            $display("FAIL nop_count got=%0d exp=2", icnt);
        end
    endtask

    task automatic test_mem_wait();
        int s4, cyc;
        mem_instr(3, s4, cyc);
        vectors++;
        if (s4 != 4 || cyc != 8 || mto !== 1'b0) begin
            miscompares++;
            $display("FAIL mem_wait3 got=s4 %0d cyc %0d to %b exp=s4 4 cyc 8 to 0", s4, cyc, mto);
        end
        vectors++;
        if (icnt !== CW'(3)) begin
            miscompares++;
            $display("FAIL mem_wait_count got=%0d exp=3", icnt);
        end
    endtask

    task automatic test_timeout();
        int s4, cyc;
        mem_instr(WM - 1, s4, cyc);
        vectors++;
        if (s4 != WM || cyc != NS - 1 + WM || mto !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_below_max got=s4 %0d cyc %0d to %b exp=s4 %0d cyc %0d to 0",
                     s4, cyc, mto, WM, NS - 1 + WM);
        end
        mem_instr(WM, s4, cyc);
        vectors++;
        if (s4 != WM + 1 || mto !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_at_max got=s4 %0d to %b exp=s4 %0d to 1", s4, mto, WM + 1);
        end
        do_reset();
        vectors++;
        if (mto !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_reset got=%b exp=0", mto);
        end
        run = 1'b1;
        tick();
        run = 1'b0;
        mem_instr(1000, s4, cyc);
        vectors++;
        if (s4 != WM + 1 || mto !== 1'b1) begin
            miscompares++;
            $display("FAIL watchdog got=s4 %0d to %b exp=s4 %0d to 1", s4, mto, WM + 1);
        end
        mem_instr(0, s4, cyc);
        vectors++;
        if (cyc != NS || mto !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_sticky got=cyc %0d to %b exp=cyc %0d to 1", cyc, mto, NS);
        end
    endtask

    task automatic test_stall();
        do_reset();
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (stage !== SW'(2) || en_dut !== 9'h000) begin
                miscompares++;
                $display("FAIL stall_hold got=stage %0d en %h exp=stage 2 en 000", stage, en_dut);
            end
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL stall_model got=%h exp=%h", obs, expv());
            end
            tick();
        end
        stall = 1'b0;
        #1;
        vectors++;
        if (stage !== SW'(2) || {rz, rm} !== 2'b11) begin
            miscompares++;
            $display("FAIL stall_release got=stage %0d rzrm %b exp=stage 2 rzrm 11",
                     stage, {rz, rm});
        end
        tick();
        rst = 1'b1;
        #1;
        vectors++;
        if (en_dut !== 9'h000) begin
            miscompares++;
            $display("FAIL reset_no_write got=%h exp=000", en_dut);
        end
        tick();
        rst = 1'b0;
        vectors++;
        if (stage !== '0 || icnt !== '0) begin
            miscompares++;
            $display("FAIL mid_reset got=stage %0d cnt %0d exp=stage 0 cnt 0", stage, icnt);
        end
    endtask

    task automatic test_halt();
        do_reset();
        run = 1'b1;
        tick();
        run = 1'b0;
        halt = 1'b1;
        nop = 1'b1;
        #1;
        vectors++;
        if (en_dut !== 9'h000) begin
            miscompares++;
            $display("FAIL halt_cycle_en got=%h exp=000", en_dut);
        end
        tick();
        halt = 1'b0;
        nop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run = 1'($urandom % 2);
            stall = 1'($urandom % 2);
            mrdy = 1'($urandom % 2);
            #1;
            vectors++;
            if (halted !== 1'b1 || stage !== SW'(1) || en_dut !== 9'h000) begin
                miscompares++;
                $display("FAIL halted_hold got=h%b stage %0d en %h exp=h1 stage 1 en 000",
                         halted, stage, en_dut);
            end
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL halt_model got=%h exp=%h", obs, expv());
            end
            tick();
        end
        run = 1'b0; stall = 1'b0; mrdy = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (stage !== '0 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_reset got=stage %0d h %b exp=stage 0 h 0", stage, halted);
        end
    endtask

    task automatic test_random();
        int burst;
        burst = 0;
        do_reset();
        for (int i = 0; i < 900; i++) begin
            rst   = ($urandom % 90 == 0);
            run   = 1'($urandom % 2);
            stall = ($urandom % 6 == 0);
            halt  = ($urandom % 40 == 0);
            nop   = ($urandom % 4 == 0);
            if (burst == 0 && $urandom % 40 == 0) burst = 10 + int'($urandom % 10);
            if (burst > 0) begin
                mrdy = 1'b0;
                burst--;
            end else begin
                mrdy = ($urandom % 4 != 0);
            end
            #1;
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL random_model i=%0d got=%h exp=%h", i, obs, expv());
            end
            tick();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        @(negedge clk);
        #1;
        test_reset();
        test_normal();
        test_nop();
        test_mem_wait();
        test_timeout();
        test_stall();
        test_halt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
